// File: rtl/conv_window_issuer.sv
// conv_window_issuer: walks every valid 3x3 window of an img_w x img_h image
// (stride 1, no padding, raster order), fetches the nine pixels, hands the
// window plus nine weights to a 3x3 conv engine and writes each result.
// Optional build macro: CONV_RELU_EN -- when defined, negative results
// (sign bit set) are written as 0x0000; otherwise results pass unmodified.
module conv_window_issuer #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        img_w,
    input  logic [7:0]        img_h,
    input  logic [ADDR_W-1:0] base_in,
    input  logic [ADDR_W-1:0] base_out,
    input  logic [143:0]      w_in,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic [143:0]      im,
    output logic [143:0]      iw,
    output logic              conv_ready,
    input  logic              conv_valid,
    input  logic [15:0]       om,
    output logic              conv_rst_n,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_WRITE = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [7:0]        x_q, x_d, y_q, y_d;
    logic [3:0]        k_q, k_d;
    logic [7:0]        img_w_q, img_w_d, img_h_q, img_h_d;
    logic [ADDR_W-1:0] base_in_q, base_in_d, base_out_q, base_out_d;
    logic [143:0]      im_q, im_d, iw_q, iw_d;
    logic [15:0]       om_q, om_d;

    logic [7:0]        kx, ky, row_idx, col_idx, out_w;
    logic [15:0]       rd_row_off, wr_row_off;
    logic [ADDR_W-1:0] rd_addr_calc, wr_addr_calc;
    logic [15:0]       result;

    // Fetch address: k counts 0..8 across the window, row-major within it.
    always_comb begin
        kx           = {4'd0, k_q % 4'd3};
        ky           = {4'd0, k_q / 4'd3};
        row_idx      = y_q + ky;
        col_idx      = x_q + kx;
        rd_row_off   = {8'd0, row_idx} * {8'd0, img_w_q};
        rd_addr_calc = base_in_q + ADDR_W'(rd_row_off) + ADDR_W'(col_idx);
        out_w        = img_w_q - 8'd2;
        wr_row_off   = {8'd0, y_q} * {8'd0, out_w};
        wr_addr_calc = base_out_q + ADDR_W'(wr_row_off) + ADDR_W'(x_q);
    end

    // Result post-processing: optional ReLU on the fp16 sign bit.
    always_comb begin
`ifdef CONV_RELU_EN
        result = om_q[15] ? 16'h0000 : om_q;
`else
        result = om_q;
`endif
    end

    // Output decode; address/data buses read zero outside their strobes.
    always_comb begin
        rd_en      = (state_q == S_FETCH) && (k_q < 4'd9);
        rd_addr    = rd_en ? rd_addr_calc : '0;
        wr_en      = (state_q == S_WRITE);
        wr_addr    = wr_en ? wr_addr_calc : '0;
        wr_data    = wr_en ? result : 16'h0000;
        conv_ready = (state_q == S_ISSUE);
        done       = (state_q == S_DONE);
        busy       = (state_q != S_IDLE) && (state_q != S_DONE);
        conv_rst_n = rst_n && (state_q != S_CLR);
        im         = im_q;
        iw         = iw_q;
    end

    // Job sequencing: window walk, fetch/capture, engine handshake, write-back.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        k_d        = k_q;
        img_w_d    = img_w_q;
        img_h_d    = img_h_q;
        base_in_d  = base_in_q;
        base_out_d = base_out_q;
        im_d       = im_q;
        iw_d       = iw_q;
        om_d       = om_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((img_w >= 8'd3) && (img_h >= 8'd3)) begin
                        img_w_d    = img_w;
                        img_h_d    = img_h;
                        base_in_d  = base_in;
                        base_out_d = base_out;
                        iw_d       = w_in;
                        x_d        = 8'd0;
                        y_d        = 8'd0;
                        state_d    = S_CLR;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_CLR: begin
                k_d     = 4'd0;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // Data for request k-1 is valid while k is current.
                for (int i = 0; i < 9; i++) begin
                    if (k_q == 4'(i + 1)) begin
                        im_d[16*i +: 16] = rd_data;
                    end
                end
                if (k_q == 4'd9) begin
                    state_d = S_ISSUE;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (conv_valid) begin
                    om_d    = om;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (x_q == img_w_q - 8'd3) begin
                    x_d = 8'd0;
                    if (y_q == img_h_q - 8'd3) begin
                        state_d = S_DONE;
                    end else begin
                        y_d     = y_q + 8'd1;
                        state_d = S_CLR;
                    end
                end else begin
                    x_d     = x_q + 8'd1;
                    state_d = S_CLR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            x_q        <= 8'd0;
            y_q        <= 8'd0;
            k_q        <= 4'd0;
            img_w_q    <= 8'd0;
            img_h_q    <= 8'd0;
            base_in_q  <= '0;
            base_out_q <= '0;
            im_q       <= '0;
            iw_q       <= '0;
            om_q       <= 16'h0000;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            k_q        <= k_d;
            img_w_q    <= img_w_d;
            img_h_q    <= img_h_d;
            base_in_q  <= base_in_d;
            base_out_q <= base_out_d;
            im_q       <= im_d;
            iw_q       <= iw_d;
            om_q       <= om_d;
        end
    end

endmodule

// File: tb/tb_conv_window_issuer.sv
// Self-checking bench for conv_window_issuer: pixel memory, sticky-valid conv
// engine model, window-list reference model and a per-cycle output monitor.
module tb_conv_window_issuer;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [7:0]    img_w, img_h;
    logic [15:0]   base_in, base_out;
    logic [143:0]  w_in;
    logic          rd_en, wr_en, conv_ready, conv_valid, conv_rst_n, busy, done;
    logic [15:0]   rd_addr, wr_addr, wr_data, rd_data, om;
    logic [143:0]  im, iw;

    logic [15:0]   mem [0:65535];
    logic [15:0]   om_seed;
    logic          eng_active;
    int            eng_cnt;

    int            n_cmp = 0;
    int            n_err = 0;
    int            done_cnt = 0;
    int            wr_cnt = 0;
    int            ready_cnt = 0;
    int            rd_run = 0;
    logic [15:0]   last_wd = 16'h0;
    logic [143:0]  held_im = '0;
    logic [143:0]  cur_w = '0;

    logic [15:0]   exp_rd [$];
    logic [143:0]  exp_im [$];
    logic [15:0]   exp_wa [$];
    logic [15:0]   exp_wd [$];

    conv_window_issuer #(.ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .img_w(img_w), .img_h(img_h),
        .base_in(base_in), .base_out(base_out), .w_in(w_in),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .im(im), .iw(iw), .conv_ready(conv_ready), .conv_valid(conv_valid),
        .om(om), .conv_rst_n(conv_rst_n), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Pixel memory: data valid one cycle after the request.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    // Engine model: result = centre pixel + om_seed; valid rises 20 cycles
    // after conv_ready and stays high until conv_rst_n clears it.
    always @(posedge clk) begin
        if (!conv_rst_n) begin
            conv_valid <= 1'b0;
            eng_active <= 1'b0;
            eng_cnt    <= 0;
        end else if (conv_ready) begin
            eng_active <= 1'b1;
            eng_cnt    <= 1;
            om         <= im[79:64] + om_seed;
        end else if (eng_active) begin
            if (eng_cnt == 19) begin
                conv_valid <= 1'b1;
                eng_active <= 1'b0;
            end else begin
                eng_cnt <= eng_cnt + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef CONV_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [143:0] mk_w(input logic [15:0] b);
        logic [143:0] r;
        for (int k = 0; k < 9; k++) r[16*k +: 16] = b + 16'(k);
        return r;
    endfunction

    // Reference model: enumerate every valid window in raster order.
    task automatic build_job(input int w, input int h, input int bi, input int bo);
        logic [143:0] win;
        logic [15:0]  c;
        int           a;
        int           wa;
        if (w < 3 || h < 3) return;
        for (int yy = 0; yy <= h - 3; yy++) begin
            for (int xx = 0; xx <= w - 3; xx++) begin
                for (int k = 0; k < 9; k++) begin
                    a = bi + (yy + k / 3) * w + xx + k % 3;
                    exp_rd.push_back(a[15:0]);
                    win[16*k +: 16] = mem[a[15:0]];
                end
                exp_im.push_back(win);
                c  = win[79:64] + om_seed;
                wa = bo + yy * (w - 2) + xx;
                exp_wa.push_back(wa[15:0]);
                exp_wd.push_back(relu(c));
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [7:0] w, input logic [7:0] h,
                             input logic [15:0] bi, input logic [15:0] bo,
                             input logic [143:0] wts);
        img_w = w; img_h = h; base_in = bi; base_out = bo; w_in = wts;
        start = 1'b1;
        cycle();
        start = 1'b0;
        // Scramble configuration; the running job must not notice.
        img_w = 8'd7; img_h = 8'd9; base_in = 16'hBEEF; base_out = 16'h7777;
        w_in = ~wts;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 3000) begin
            cycle();
            n++;
        end
        chk("done_count", 144'(done_cnt), 144'(target));
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_conv_ready", conv_ready, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_im", im, 0);
        chk("rst_iw", iw, 0);
        chk("rst_conv_rst_n", conv_rst_n, 0);
    endtask

    initial begin
        int base_wr;
        int seen;
        rst_n = 1'b0; start = 1'b0; img_w = 8'd0; img_h = 8'd0;
        base_in = 16'h0; base_out = 16'h0; w_in = '0; om_seed = 16'h0;
        for (int a = 0; a < 65536; a++) mem[a] = 16'(a - 256);

        // Per-cycle monitor: every strobe is checked against the model queues.
        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    if (rd_en) begin
                        if (exp_rd.size() == 0) chk("rd_unexpected", rd_en, 0);
                        else chk("rd_addr", rd_addr, exp_rd.pop_front());
                        rd_run++;
                    end else if (rd_run != 0) begin
                        chk("rd_burst_len", 144'(rd_run), 144'd9);
                        rd_run = 0;
                    end
                    if (conv_ready) begin
                        ready_cnt++;
                        held_im = im;
                        if (exp_im.size() == 0) chk("ready_unexpected", conv_ready, 0);
                        else chk("im_window", im, exp_im.pop_front());
                        chk("iw_weights", iw, cur_w);
                    end
                    if (wr_en) begin
                        $display("wr addr=%04h data=%04h", wr_addr, wr_data);
                        if (exp_wa.size() == 0) chk("wr_unexpected", wr_en, 0);
                        else begin
                            chk("wr_addr", wr_addr, exp_wa.pop_front());
                            chk("wr_data", wr_data, exp_wd.pop_front());
                            chk("im_hold", im, held_im);
                        end
                        last_wd = wr_data;
                        wr_cnt++;
                    end
                    if (done) begin
                        done_cnt++;
                        chk("busy_at_done", busy, 0);
                    end
                end else begin
                    rd_run = 0;
                end
            end
        join_none

        // Reset state.
        repeat (3) cycle();
        @(negedge clk);
        check_reset_outputs();
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("conv_rst_n_idle", conv_rst_n, 1);
        chk("busy_idle", busy, 0);

        // 3x3 job, single window.
        om_seed = 16'h1000;
        cur_w = mk_w(16'h3C00);
        build_job(3, 3, 16'h0100, 16'h0300);
        chk("lit_rd0", exp_rd[0], 16'h0100);
        chk("lit_rd8", exp_rd[8], 16'h0108);
        chk("lit_im0", exp_im[0], 144'h0008_0007_0006_0005_0004_0003_0002_0001_0000);
        chk("lit_wa0", exp_wa[0], 16'h0300);
        start_job(8'd3, 8'd3, 16'h0100, 16'h0300, cur_w);
        wait_done(1);
        chk("A_wr_count", 144'(wr_cnt), 144'd1);
        chk("A_last_wd", last_wd, 16'h1004);

        // 4x4 job, with a stray start pulse during the first fetch.
        om_seed = 16'h0000;
        cur_w = mk_w(16'h4100);
        build_job(4, 4, 16'h0100, 16'h0200);
        chk("lit_w2_rd0", exp_rd[9], 16'h0101);
        chk("lit_w2_rd3", exp_rd[12], 16'h0105);
        chk("lit_w2_rd8", exp_rd[17], 16'h010B);
        chk("lit_w3_rd0", exp_rd[18], 16'h0104);
        chk("lit_wa3", exp_wa[3], 16'h0203);
        chk("lit_wd3", exp_wd[3], 16'h000A);
        start_job(8'd4, 8'd4, 16'h0100, 16'h0200, cur_w);
        seen = 0;
        for (int n = 0; n < 50 && seen == 0; n++) begin
            if (rd_en) seen = 1;
            else cycle();
        end
        chk("B_fetch_seen", 144'(seen), 144'd1);
        img_w = 8'd3; img_h = 8'd3; base_in = 16'h0000; start = 1'b1;
        cycle();
        start = 1'b0;
        wait_done(2);
        chk("B_wr_count", 144'(wr_cnt), 144'd5);
        chk("B_last_wd", last_wd, 16'h000A);

        // Degenerate image: done straight away, no memory traffic.
        img_w = 8'd2; img_h = 8'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("C_done_pulse", done, 1);
        chk("C_busy", busy, 0);
        cycle();
        wait_done(3);
        chk("C_wr_count", 144'(wr_cnt), 144'd5);

        // Negative and positive results.
        om_seed = 16'hBFFC;
        cur_w = mk_w(16'h0011);
        build_job(3, 3, 16'h0100, 16'h0400);
`ifdef CONV_RELU_EN
        chk("lit_relu_neg", exp_wd[0], 16'h0000);
`else
        chk("lit_relu_neg", exp_wd[0], 16'hC000);
`endif
        start_job(8'd3, 8'd3, 16'h0100, 16'h0400, cur_w);
        wait_done(4);
`ifdef CONV_RELU_EN
        chk("D_neg_wd", last_wd, 16'h0000);
`else
        chk("D_neg_wd", last_wd, 16'hC000);
`endif
        om_seed = 16'h3FFC;
        build_job(3, 3, 16'h0100, 16'h0401);
        start_job(8'd3, 8'd3, 16'h0100, 16'h0401, cur_w);
        wait_done(5);
        chk("D_pos_wd", last_wd, 16'h4000);

        // Reset while waiting on window 2 of a 4x4 job.
        om_seed = 16'h0000;
        cur_w = mk_w(16'h2200);
        base_wr = wr_cnt;
        seen = ready_cnt + 2;
        build_job(4, 4, 16'h0100, 16'h0500);
        start_job(8'd4, 8'd4, 16'h0100, 16'h0500, cur_w);
        for (int n = 0; n < 500 && ready_cnt < seen; n++) cycle();
        chk("E_reached_w2", 144'(ready_cnt), 144'(seen));
        repeat (5) cycle();
        rst_n = 1'b0;
        exp_rd.delete(); exp_im.delete(); exp_wa.delete(); exp_wd.delete();
        @(negedge clk);
        check_reset_outputs();
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (30) cycle();
        chk("E_no_write_after_rst", 144'(wr_cnt), 144'(base_wr + 1));
        chk("E_no_done", 144'(done_cnt), 144'd5);
        om_seed = 16'h1000;
        cur_w = mk_w(16'h3C00);
        build_job(3, 3, 16'h0100, 16'h0300);
        start_job(8'd3, 8'd3, 16'h0100, 16'h0300, cur_w);
        wait_done(6);
        chk("E_wr_count", 144'(wr_cnt), 144'(base_wr + 2));
        chk("E_last_wd", last_wd, 16'h1004);

        repeat (5) cycle();
        chk("queues_drained", 144'(exp_rd.size() + exp_wa.size() + exp_im.size()), 144'd0);
        chk("final_done_count", 144'(done_cnt), 144'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv_window_issuer.md
CONV_WINDOW_ISSUER -- requirements
Module: conv_window_issuer

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, width of read/write memory addresses.
REQ-002 SHALL have ports: clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle job request, sampled in IDLE only.
REQ-005 img_w, img_h  input  8 each  input image width/height in pixels; sampled at start.
REQ-006 base_in, base_out  input  ADDR_W each  input/output buffer base addresses; sampled at start.
REQ-007 w_in  input  144  nine packed fp16 weights, lane k at bits [16k+15:16k]; sampled at start.
REQ-008 rd_en  output  1; rd_addr  output  ADDR_W; rd_data  input  16  pixel memory, data valid exactly 1 cycle after rd_en.
REQ-009 wr_en  output  1; wr_addr  output  ADDR_W; wr_data  output  16  result memory write, one cycle per result.
REQ-010 im, iw  output  144 each  packed window and weights to the 3x3 conv engine.
REQ-011 conv_ready  output  1; conv_valid  input  1; om  input  16  engine handshake and result.
REQ-012 conv_rst_n  output  1  engine-local active-low reset.
REQ-013 busy  output  1; done  output  1  job active / one-cycle completion pulse.

Function
REQ-014 SHALL compute all valid windows: stride 1, no padding, output size (img_w-2) x (img_h-2), raster order (x fastest).
REQ-015 SHALL use states IDLE, CLR, FETCH, ISSUE, WAIT, WRITE, DONE.
REQ-016 IDLE: start=1 with img_w>=3 and img_h>=3 -> CLR, x=y=0, busy=1; start=1 with either dimension <3 -> DONE, no reads/writes.
REQ-017 CLR: conv_rst_n=0 for exactly one cycle; this clears sticky conv_valid before each window; -> FETCH.
REQ-018 FETCH: rd_en=1 for 9 consecutive cycles, k=0..8, ky=k/3, kx=k%3, rd_addr = base_in + (y+ky)*img_w + (x+kx), modulo 2^ADDR_W.
REQ-019 rd_data returned one cycle after request k SHALL be stored in im lane k; -> ISSUE on the cycle after the 9th capture.
REQ-020 ISSUE: conv_ready=1 for exactly one cycle; -> WAIT.
REQ-021 WAIT: im and iw SHALL hold stable; on conv_valid=1 latch om -> WRITE; no timeout.
REQ-022 WRITE: wr_en=1 one cycle, wr_addr = base_out + y*(img_w-2) + x, wr_data = latched om (see REQ-029); advance x, wrap to 0 and increment y at x=img_w-3; last window -> DONE, else -> CLR.
REQ-023 DONE: done=1 one cycle, busy=0 -> IDLE.
REQ-024 iw SHALL equal w_in latched at start and stay constant for the job.
REQ-025 start while busy SHALL be ignored; config inputs changed mid-job SHALL have no effect.
REQ-026 rd_en, wr_en, conv_ready, done SHALL be 0 in all states not listed above for them.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE; busy, done, rd_en, wr_en, conv_ready = 0; rd_addr, wr_addr, wr_data, im, iw, x, y = 0; conv_rst_n = 0 while rst_n=0, 1 otherwise outside CLR.
REQ-028 Reset mid-job SHALL abandon the job with no further writes; next start begins a fresh job.

Configuration
REQ-029 Macro CONV_RELU_EN: defined -> wr_data = 0x0000 when om[15]=1, else om (ReLU); undefined -> wr_data = om unmodified.

Verification (bench uses engine model: conv_valid sticky high N=20 cycles after conv_ready, cleared by conv_rst_n)
REQ-030 img 3x3, base_in=0x0100, mem[0x0100+i]=i -> rd_addr 0x0100..0x0108 in 9 consecutive cycles, im lane k = k, one write at base_out, one done pulse.
REQ-031 img 4x4, base_out=0x0200 -> 4 writes at 0x0200..0x0203; window 2 reads 0x0101,0x0102,0x0103,0x0105,...,0x010B; window 3 starts 0x0104.
REQ-032 img_w=2, start -> done next cycle after DONE entry, rd_en and wr_en never asserted.
REQ-033 om=0xC000 -> wr_data 0x0000 with CONV_RELU_EN, 0xC000 without; om=0x4000 -> 0x4000 both builds.
REQ-034 rst_n low during WAIT of window 2 of 4x4 job -> all outputs at reset values, no further wr_en; new 3x3 job completes per REQ-030.
REQ-035 start pulsed during FETCH of job -> ignored, write count and done count unchanged.
